// File: rtl/imem_loader_if.sv
// Byte-stream load port and CPU fetch port of the instruction-memory loader.
// The source/CPU side uses "master" and the loader uses "slave".
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] pc;
    logic [31:0] inst;

    modport master (
        output byte_valid, byte_data, pc,
        input  byte_ready, inst
    );

    modport slave (
        input  byte_valid, byte_data, pc,
        output byte_ready, inst
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a checksummed big-endian program image into instruction RAM while holding the
// CPU in reset, then serves zero-latency instruction fetches.
module imem_loader #(
    parameter int          DEPTH   = 1024,
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] PC_BASE = 32'h0040_0000
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          load_done,
    output logic          load_err,
    output logic [15:0]   words_loaded
);

    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

    state_t      state, state_nxt;
    logic [15:0] count;
    logic [15:0] word_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic [23:0] word_sr;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic [15:0] hdr_cnt;
    logic        word_end;
    logic [31:0] fetch_off;
    logic        fetch_ok;

    assign accept   = bus.byte_valid && bus.byte_ready;
    assign hdr_cnt  = {count[15:8], bus.byte_data};
    assign word_end = (byte_idx == 2'd3);

    // NOTE: every output of this block gets a default before the case, so no latch can form.
    always_comb begin
        state_nxt      = state;
        bus.byte_ready = 1'b0;
        case (state)
            HDR0: begin
                bus.byte_ready = 1'b1;
                if (accept) state_nxt = HDR1;
            end
            HDR1: begin
                bus.byte_ready = 1'b1;
                if (accept) begin
                    if ({16'd0, hdr_cnt} > 32'(DEPTH)) state_nxt = ERR;
                    else if (hdr_cnt == 16'd0)         state_nxt = CSUM;
                    else                               state_nxt = DATA;
                end
            end
            DATA: begin
                bus.byte_ready = 1'b1;
                if (accept && word_end && (word_cnt + 16'd1 == count)) state_nxt = CSUM;
            end
            CSUM: begin
                bus.byte_ready = 1'b1;
                if (accept) state_nxt = (bus.byte_data == csum) ? DONE : ERR;
            end
            default: state_nxt = state;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HDR0;
            word_cnt <= '0;
            byte_idx <= '0;
            count    <= '0;
            csum     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                case (state)
                    HDR0: count[15:8] <= bus.byte_data;
                    HDR1: count[7:0]  <= bus.byte_data;
                    DATA: begin
                        word_sr  <= {word_sr[15:0], bus.byte_data};
                        csum     <= csum ^ bus.byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (word_end) word_cnt <= word_cnt + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the RAM has no reset; a new image overwrites it and fetches are gated until verified.
    always_ff @(posedge clk) begin
        if (!rst && accept && state == DATA && word_end)
            mem[word_cnt[ADDR_W-1:0]] <= {word_sr, bus.byte_data};
    end

    assign load_done    = (state == DONE);
    assign load_err     = (state == ERR);
    assign cpu_rst      = ~load_done;
    assign words_loaded = word_cnt;

    // Out-of-window or misaligned fetches return a nop rather than an aliased word.
    assign fetch_off = bus.pc - PC_BASE;
    assign fetch_ok  = load_done && (fetch_off < 32'(DEPTH) * 32'd4) && (bus.pc[1:0] == 2'b00);
    assign bus.inst  = fetch_ok ? mem[fetch_off[ADDR_W+1:2]] : 32'h0000_0000;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built images and checks load status and
// fetch results against hand-computed values.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_rst, load_done, load_err;
    logic [15:0] words_loaded;
    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  model_csum;

    imem_loader_if bus ();

    imem_loader #(.DEPTH(1024), .ADDR_W(10), .PC_BASE(BASE)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .cpu_rst      (cpu_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_csum = 8'h00;
    endtask

    // Presents one byte and returns #1 after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.byte_ready) begin
            check("ready_wait", {31'd0, bus.byte_ready}, 32'd1);
            bus.byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.byte_valid = 1'b0;
        end
    endtask

    task automatic send_byte_gap(input logic [7:0] b, input int gaps);
        for (int i = 0; i < gaps; i++) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            bus.byte_data  = ~b;
        end
        send_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            model_csum = model_csum ^ w[8*i +: 8];
        end
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.pc = addr;
        #1 check(tag, bus.inst, exp);
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [15:0] v = 16'(i);
        return {v[7:0] ^ 8'h5A, v[15:8], 8'hC3, v[7:0]};
    endfunction

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.pc         = BASE;
        rst            = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_ready", {31'd0, bus.byte_ready}, 32'd1);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);

        // 1: single-word image, checksum 24^08^00^05 = 29
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        check("t1_words_pre", {16'd0, words_loaded}, 32'd1);
        check("t1_cpu_rst_pre", {31'd0, cpu_rst}, 32'd1);
        check_fetch("t6_fetch_before_done", BASE, 32'h0);
        send_byte(8'h29);
        check("t1_done", {31'd0, load_done}, 32'd1);
        check("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("t1_words", {16'd0, words_loaded}, 32'd1);
        check("t1_ready_done", {31'd0, bus.byte_ready}, 32'd0);
        check_fetch("t1_fetch0", BASE, 32'h2408_0005);
        check_fetch("t1_fetch1", 32'h0040_0004, 32'h0);
        check_fetch("t6_misaligned", 32'h0040_0002, 32'h0);
        check_fetch("t6_below_base", 32'h003F_FFFC, 32'h0);
        // A byte offered in DONE must be ignored.
        @(negedge clk); bus.byte_valid = 1'b1; bus.byte_data = 8'hAB;
        repeat (3) @(negedge clk);
        bus.byte_valid = 1'b0;
        check("t6_done_ignores", {16'd0, words_loaded}, 32'd1);
        check("t6_done_stays", {31'd0, load_done}, 32'd1);

        // 2: two-word image; checksum of 3C 01 10 01 8C 22 00 00 is 82
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h3C01_1001); send_word(32'h8C22_0000);
        send_byte(8'h82);
        check("t2_done", {31'd0, load_done}, 32'd1);
        check_fetch("t2_fetch0", BASE, 32'h3C01_1001);
        check_fetch("t2_fetch1", 32'h0040_0004, 32'h8C22_0000);
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h3C01_1001); send_word(32'h8C22_0000);
        send_byte(8'h11);
        check("t2_err", {31'd0, load_err}, 32'd1);
        check("t2_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("t2_err_words", {16'd0, words_loaded}, 32'd2);
        check("t2_err_ready", {31'd0, bus.byte_ready}, 32'd0);
        check_fetch("t2_err_fetch", BASE, 32'h0);

        // 3: N = DEPTH+1 errors at header; N = DEPTH loads fully
        do_reset();
        send_byte(8'h04);
        check("t3_hdr0_err", {31'd0, load_err}, 32'd0);
        send_byte(8'h01);
        check("t3_over_err", {31'd0, load_err}, 32'd1);
        check("t3_over_words", {16'd0, words_loaded}, 32'd0);
        check("t3_over_ready", {31'd0, bus.byte_ready}, 32'd0);
        do_reset();
        send_byte(8'h04); send_byte(8'h00);
        for (int i = 0; i < 1024; i++) send_word(pat(i));
        check("t3_full_not_done", {31'd0, load_done}, 32'd0);
        send_byte(model_csum);
        check("t3_full_done", {31'd0, load_done}, 32'd1);
        check("t3_full_words", {16'd0, words_loaded}, 32'd1024);
        check_fetch("t3_first", BASE, 32'h5A00_C300);
        check_fetch("t3_last", 32'h0040_0FFC, 32'hA503_C3FF);
        check_fetch("t3_past_end", 32'h0040_1000, 32'h0);

        // 4: empty image needs checksum 00
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("t4_empty_done", {31'd0, load_done}, 32'd1);
        check("t4_empty_words", {16'd0, words_loaded}, 32'd0);
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("t4_empty_err", {31'd0, load_err}, 32'd1);

        // 5: reset mid-load, then a gapped one-word image (DE^AD^BE^EF = 22)
        do_reset();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("t5_mid_words", {16'd0, words_loaded}, 32'd1);
        do_reset();
        #1;
        check("t5_rst_words", {16'd0, words_loaded}, 32'd0);
        check("t5_rst_ready", {31'd0, bus.byte_ready}, 32'd1);
        check("t5_rst_done", {31'd0, load_done}, 32'd0);
        send_byte_gap(8'h00, 2); send_byte_gap(8'h01, 3);
        send_byte_gap(8'hDE, 1); send_byte_gap(8'hAD, 4);
        send_byte_gap(8'hBE, 2); send_byte_gap(8'hEF, 1);
        check("t6_gap_words", {16'd0, words_loaded}, 32'd1);
        send_byte_gap(8'h22, 3);
        check("t5_done", {31'd0, load_done}, 32'd1);
        check_fetch("t5_fetch", BASE, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
